fixed_point_multiplier: RTL

FIXED_POINT_MULTIPLIER -- requirements
Module: fixed_point_multiplier

---
 rtl/fixed_point_multiplier.sv | 105 ++++++++++
 1 files changed

// File: rtl/fixed_point_multiplier.sv
// Sequential unsigned Q(W-F).F multiplier: one shift-add step per clock over W cycles,
// truncating the fraction and saturating to all ones when the integer part overflows.
module fixed_point_multiplier #(
    parameter int unsigned W = 10,
    parameter int unsigned F = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sclr,
    input  logic [W-1:0] ain,
    input  logic [W-1:0] bin,
    input  logic         start,
    output logic [W-1:0] qout,
    output logic         ovf,
    output logic         busy,
    output logic         valid
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] mcand;
    logic [W-1:0]  mplier;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;

    logic [PW-1:0] acc_next_c;
    logic [PW-1:0] hi_bits_c;
    logic [W-1:0]  res_c;
    logic          ovf_c;

    // Accumulator after this cycle's step; on the last step it is the full product.
    always_comb begin
        acc_next_c = acc;
        if (mplier[0]) begin
            acc_next_c = acc + mcand;
        end
        hi_bits_c = acc_next_c >> (W + F);
        res_c     = W'(acc_next_c >> F);
        ovf_c     = |hi_bits_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            qout   <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else if (sclr) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            qout   <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= PW'(ain);
                        mplier <= bin;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        valid  <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here
                    acc    <= acc_next_c;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        qout  <= ovf_c ? '1 : res_c;
                        ovf   <= ovf_c;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
